alu_issue_queue: RTL and testbench

- Buffered issue/retire stage that sits directly upstream and downstream of the 8-bit combinational ALU (A, B, OP[2:0] in; Y, C, V, N, Z out).
- Accepts operand/opcode commands over a valid/ready handshake and queues them in a FIFO.
- Presents the FIFO head to the ALU, registers the ALU result and flags, and returns them over a valid/ready result handshake with a sequence tag.
- Keeps a sticky overflow status bit.

---
 rtl/alu_issue_queue_if.sv | 60 ++++++
 rtl/alu_issue_queue.sv | 124 ++++++++++++
 tb/tb_alu_issue_queue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Command, ALU and result bundle for alu_issue_queue.
// slave: the issue queue; master: command source, ALU and result sink.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            CMD_VALID;
    logic            CMD_READY;
    logic [7:0]      CMD_A;
    logic [7:0]      CMD_B;
    logic [2:0]      CMD_OP;

    logic [7:0]      ALU_A;
    logic [7:0]      ALU_B;
    logic [2:0]      ALU_OP;
    logic [7:0]      ALU_Y;
    logic            ALU_C;
    logic            ALU_V;
    logic            ALU_N;
    logic            ALU_Z;

    logic            RES_VALID;
    logic            RES_READY;
    logic [7:0]      RES_Y;
    logic            RES_C;
    logic            RES_V;
    logic            RES_N;
    logic            RES_Z;
    logic [TAGW-1:0] RES_TAG;

    logic            OVF_STICKY;
    logic            CLR_STICKY;
    logic [CW-1:0]   COUNT;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_OP,
        output CMD_READY,
        output ALU_A, ALU_B, ALU_OP,
        input  ALU_Y, ALU_C, ALU_V, ALU_N, ALU_Z,
        output RES_VALID, RES_Y, RES_C, RES_V, RES_N, RES_Z, RES_TAG,
        input  RES_READY,
        output OVF_STICKY,
        input  CLR_STICKY,
        output COUNT
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_OP,
        input  CMD_READY,
        input  ALU_A, ALU_B, ALU_OP,
        output ALU_Y, ALU_C, ALU_V, ALU_N, ALU_Z,
        input  RES_VALID, RES_Y, RES_C, RES_V, RES_N, RES_Z, RES_TAG,
        output RES_READY,
        input  OVF_STICKY,
        output CLR_STICKY,
        input  COUNT
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue/retire buffer around a combinational 8-bit ALU: command FIFO,
// head drive to the ALU, registered tagged result and sticky overflow.
// Ports: CLK, RST_N (async active-low), bus (alu_issue_queue_if.slave).
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    alu_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]      mem_a   [DEPTH];
    logic [7:0]      mem_b   [DEPTH];
    logic [2:0]      mem_op  [DEPTH];
    logic [TAGW-1:0] mem_tag [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TAGW-1:0] tag_cnt;

    logic            res_valid;
    logic [7:0]      res_y;
    logic            res_c;
    logic            res_v;
    logic            res_n;
    logic            res_z;
    logic [TAGW-1:0] res_tag;
    logic            ovf;

    logic            not_empty;
    logic            cmd_ready;
    logic            push;
    logic            load;

    assign not_empty = (count != '0);
    // Full is decided on the registered count only: no bypass on pop.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = bus.CMD_VALID & cmd_ready;
    assign load      = not_empty & (~res_valid | bus.RES_READY);

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr]   <= bus.CMD_A;
            mem_b[wr_ptr]   <= bus.CMD_B;
            mem_op[wr_ptr]  <= bus.CMD_OP;
            mem_tag[wr_ptr] <= tag_cnt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_c     <= 1'b0;
            res_v     <= 1'b0;
            res_n     <= 1'b0;
            res_z     <= 1'b0;
            res_tag   <= '0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_y     <= bus.ALU_Y;
            res_c     <= bus.ALU_C;
            res_v     <= bus.ALU_V;
            res_n     <= bus.ALU_N;
            res_z     <= bus.ALU_Z;
            res_tag   <= mem_tag[rd_ptr];
        end else if (bus.RES_READY) begin
            // Data fields hold after retirement; only valid drops.
            res_valid <= 1'b0;
        end
    end

    // A capture with V=1 wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf <= 1'b0;
        end else if (load & bus.ALU_V) begin
            ovf <= 1'b1;
        end else if (bus.CLR_STICKY) begin
            ovf <= 1'b0;
        end
    end

    assign bus.CMD_READY  = cmd_ready;
    assign bus.ALU_A      = not_empty ? mem_a[rd_ptr]  : '0;
    assign bus.ALU_B      = not_empty ? mem_b[rd_ptr]  : '0;
    assign bus.ALU_OP     = not_empty ? mem_op[rd_ptr] : '0;
    assign bus.RES_VALID  = res_valid;
    assign bus.RES_Y      = res_y;
    assign bus.RES_C      = res_c;
    assign bus.RES_V      = res_v;
    assign bus.RES_N      = res_n;
    assign bus.RES_Z      = res_z;
    assign bus.RES_TAG    = res_tag;
    assign bus.OVF_STICKY = ovf;
    assign bus.COUNT      = count;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized self-checking bench for alu_issue_queue with an adder ALU
// stub and a queue-based reference model compared every cycle.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    logic CLK;
    logic RST_N;

    alu_issue_queue_if #(.DEPTH(DEPTH), .TAGW(TAGW)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {c, v, n, z, y} of an 8-bit add
    function automatic logic [11:0] alu_add(logic [7:0] a, logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       v;
        s = {1'b0, a} + {1'b0, b};
        y = s[7:0];
        v = (a[7] == b[7]) && (y[7] != a[7]);
        return {s[8], v, y[7], (y == 8'h00), y};
    endfunction

    logic [11:0] stub;
    assign stub      = alu_add(bus.ALU_A, bus.ALU_B);
    assign bus.ALU_Y = stub[7:0];
    assign bus.ALU_Z = stub[8];
    assign bus.ALU_N = stub[9];
    assign bus.ALU_V = stub[10];
    assign bus.ALU_C = stub[11];

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]      a;
        logic [7:0]      b;
        logic [2:0]      op;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t            q[$];
    logic [TAGW-1:0] m_tag   = '0;
    logic            m_valid = 1'b0;
    logic [11:0]     m_res   = '0;
    logic [TAGW-1:0] m_rtag  = '0;
    logic            m_stick = 1'b0;

    // Reference model: queue semantics straight from the behaviour rules.
    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            q.delete();
            m_tag   = '0;
            m_valid = 1'b0;
            m_res   = '0;
            m_rtag  = '0;
            m_stick = 1'b0;
        end else begin
            bit   full;
            bit   pushed;
            bit   ld;
            ent_t e;
            full   = (q.size() == DEPTH);
            pushed = bus.CMD_VALID && !full;
            ld     = (q.size() != 0) && (!m_valid || bus.RES_READY);
            if (ld) begin
                e       = q.pop_front();
                m_res   = alu_add(e.a, e.b);
                m_rtag  = e.tag;
                m_valid = 1'b1;
            end else if (m_valid && bus.RES_READY) begin
                m_valid = 1'b0;
            end
            if (ld && m_res[10]) m_stick = 1'b1;
            else if (bus.CLR_STICKY) m_stick = 1'b0;
            if (pushed) begin
                e.a   = bus.CMD_A;
                e.b   = bus.CMD_B;
                e.op  = bus.CMD_OP;
                e.tag = m_tag;
                q.push_back(e);
                m_tag = m_tag + 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge CLK);
        if (RST_N) begin
            logic [7:0] ha;
            logic [7:0] hb;
            logic [2:0] hop;
            ha  = (q.size() != 0) ? q[0].a  : 8'h00;
            hb  = (q.size() != 0) ? q[0].b  : 8'h00;
            hop = (q.size() != 0) ? q[0].op : 3'd0;
            check("cmd_ready", 32'(bus.CMD_READY), 32'(q.size() != DEPTH));
            check("count", 32'(bus.COUNT), 32'(q.size()));
            check("alu_a", 32'(bus.ALU_A), 32'(ha));
            check("alu_b", 32'(bus.ALU_B), 32'(hb));
            check("alu_op", 32'(bus.ALU_OP), 32'(hop));
            check("res_valid", 32'(bus.RES_VALID), 32'(m_valid));
            check("res_flags_y",
                  32'({bus.RES_C, bus.RES_V, bus.RES_N, bus.RES_Z, bus.RES_Y}),
                  32'(m_res));
            check("res_tag", 32'(bus.RES_TAG), 32'(m_rtag));
            check("ovf", 32'(bus.OVF_STICKY), 32'(m_stick));
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic cmd(logic v, logic [7:0] a, logic [7:0] b);
        bus.CMD_VALID = v;
        bus.CMD_A     = a;
        bus.CMD_B     = b;
        bus.CMD_OP    = 3'($urandom_range(0, 7));
    endtask

    function automatic logic [7:0] rnd_op8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        RST_N          = 1'b0;
        bus.CMD_VALID  = 1'b0;
        bus.CMD_A      = '0;
        bus.CMD_B      = '0;
        bus.CMD_OP     = '0;
        bus.RES_READY  = 1'b0;
        bus.CLR_STICKY = 1'b0;
        step();
        step();
        check("rst_count", 32'(bus.COUNT), 0);
        check("rst_valid", 32'(bus.RES_VALID), 0);
        check("rst_tag", 32'(bus.RES_TAG), 0);
        RST_N = 1'b1;
        step();
        check("rst_ready", 32'(bus.CMD_READY), 1);

        // Single op, tag 0
        bus.RES_READY = 1'b1;
        cmd(1'b1, 8'h05, 8'h03);
        step();
        cmd(1'b0, 8'h00, 8'h00);
        step();
        check("single_valid", 32'(bus.RES_VALID), 1);
        check("single_y", 32'(bus.RES_Y), 32'h08);
        check("single_cvnz",
              32'({bus.RES_C, bus.RES_V, bus.RES_N, bus.RES_Z}), 0);
        check("single_tag", 32'(bus.RES_TAG), 0);

        // Overflow and sticky
        cmd(1'b1, 8'h7F, 8'h01);
        step();
        cmd(1'b0, 8'h00, 8'h00);
        step();
        check("ovf_y", 32'(bus.RES_Y), 32'h80);
        check("ovf_vn", 32'({bus.RES_V, bus.RES_N}), 32'b11);
        check("ovf_sticky", 32'(bus.OVF_STICKY), 1);
        check("ovf_tag", 32'(bus.RES_TAG), 1);

        cmd(1'b1, 8'hFF, 8'h01);
        step();
        cmd(1'b0, 8'h00, 8'h00);
        step();
        check("carry_y", 32'(bus.RES_Y), 32'h00);
        check("carry_cvnz",
              32'({bus.RES_C, bus.RES_V, bus.RES_N, bus.RES_Z}), 32'b1001);
        check("carry_sticky_hold", 32'(bus.OVF_STICKY), 1);

        bus.CLR_STICKY = 1'b1;
        step();
        bus.CLR_STICKY = 1'b0;
        check("sticky_clr", 32'(bus.OVF_STICKY), 0);

        cmd(1'b1, 8'h7F, 8'h01);
        step();
        cmd(1'b0, 8'h00, 8'h00);
        bus.CLR_STICKY = 1'b1;
        step();
        bus.CLR_STICKY = 1'b0;
        check("set_wins", 32'(bus.OVF_STICKY), 1);

        // Fill with backpressure: tags 4..8
        step();
        step();
        bus.RES_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd(1'b1, 8'($urandom), 8'($urandom));
            step();
        end
        cmd(1'b0, 8'h00, 8'h00);
        check("fill_count", 32'(bus.COUNT), 4);
        check("fill_ready", 32'(bus.CMD_READY), 0);
        bus.RES_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(bus.RES_VALID), 1);
            check("drain_tag", 32'(bus.RES_TAG), 32'(4 + i));
            step();
        end
        check("drain_done", 32'(bus.RES_VALID), 0);

        // Streaming, tag wraps through 15 -> 0
        for (int i = 0; i < 20; i++) begin
            cmd(1'b1, rnd_op8(), rnd_op8());
            step();
            check("stream_count_le1", 32'(bus.COUNT <= 1), 1);
            check("stream_valid", 32'(bus.RES_VALID), 32'(i >= 1));
        end
        cmd(1'b0, 8'h00, 8'h00);

        // Stall with a held result for 6 cycles
        step();
        step();
        bus.RES_READY = 1'b0;
        cmd(1'b1, 8'h12, 8'h34);
        step();
        cmd(1'b1, 8'h56, 8'h78);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stall_y", 32'(bus.RES_Y), 32'h46);
            cmd(1'b0, 8'h00, 8'h00);
        end
        bus.RES_READY = 1'b1;
        step();
        step();

        // Reset mid-stream with 3 entries queued
        bus.RES_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd(1'b1, 8'($urandom), 8'($urandom));
            step();
        end
        cmd(1'b0, 8'h00, 8'h00);
        check("pre_rst_count", 32'(bus.COUNT), 3);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.COUNT), 0);
        check("mid_rst_valid", 32'(bus.RES_VALID), 0);
        check("mid_rst_ovf", 32'(bus.OVF_STICKY), 0);
        step();
        RST_N = 1'b1;
        step();
        check("mid_rst_ready", 32'(bus.CMD_READY), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cmd(1'($urandom_range(0, 3) != 0), rnd_op8(), rnd_op8());
            bus.RES_READY  = 1'($urandom_range(0, 2) != 0);
            bus.CLR_STICKY = 1'($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
